imem_uart_loader: RTL and testbench

//  Boot-time writer for the CPU instruction memory. It takes bytes from the UART

---
 rtl/imem_uart_loader_if.sv | 22 ++
 rtl/imem_uart_loader.sv | 129 ++++++++++++
 tb/tb_imem_uart_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_uart_loader_if.sv
// Byte-strobe input and instruction-RAM write / status bundle for imem_uart_loader.
interface imem_uart_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [30:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    modport master (
        input  rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
    );

    modport slave (
        output rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
    );
endinterface

// File: rtl/imem_uart_loader.sv
// Boot loader: packs UART bytes (A5, count lo/hi, little-endian words) into
// instruction-RAM writes and holds the CPU in reset until a full image has landed.
module imem_uart_loader #(
    parameter int MAX_WORDS      = 150,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    imem_uart_loader_if.master bus
);
    // state  | meaning
    // idle   | waiting for magic byte, cpu held
    // cnt_lo | expecting word count low byte
    // cnt_hi | expecting word count high byte, range check
    // data   | assembling words and issuing writes
    // done   | image complete, cpu released
    // err    | load aborted, cpu held, waiting for magic byte
    localparam logic [2:0] st_idle   = 3'd0;
    localparam logic [2:0] st_cnt_lo = 3'd1;
    localparam logic [2:0] st_cnt_hi = 3'd2;
    localparam logic [2:0] st_data   = 3'd3;
    localparam logic [2:0] st_done   = 3'd4;
    localparam logic [2:0] st_err    = 3'd5;

    localparam int IW = $clog2(MAX_WORDS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] idle_reload  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   max_words_16 = 16'(MAX_WORDS);

    logic [2:0]    state;
    logic [15:0]   word_cnt;
    logic [IW-1:0] word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   asm_reg;
    logic [TW-1:0] idle_cnt;
    logic          last_pend;
    logic [15:0]   cnt_full;
    logic          is_magic;
    logic          timed_out;
    logic          last_word;

    assign cnt_full  = {bus.rx_data, word_cnt[7:0]};
    assign is_magic  = bus.rx_valid && (bus.rx_data == 8'hA5);
    assign timed_out = (idle_cnt == '0);
    assign last_word = (16'(word_idx) == (word_cnt - 16'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= st_idle;
            word_cnt  <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            asm_reg   <= '0;
            idle_cnt  <= '0;
            last_pend <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                st_cnt_lo: begin
                    if (bus.rx_valid) begin
                        word_cnt[7:0] <= bus.rx_data;
                        idle_cnt      <= idle_reload;
                        state         <= st_cnt_hi;
                    end else if (timed_out) begin
                        state <= st_err;
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end
                st_cnt_hi: begin
                    if (bus.rx_valid) begin
                        word_cnt[15:8] <= bus.rx_data;
                        idle_cnt       <= idle_reload;
                        word_idx       <= '0;
                        byte_idx       <= '0;
                        last_pend      <= 1'b0;
                        if (cnt_full == 16'd0)
                            state <= st_done;
                        else if (cnt_full > max_words_16)
                            state <= st_err;
                        else
                            state <= st_data;
                    end else if (timed_out) begin
                        state <= st_err;
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end
                st_data: begin
                    // Final write is on the bus this cycle; release only once it is out.
                    if (last_pend) begin
                        state <= st_done;
                    end else if (bus.rx_valid) begin
                        idle_cnt <= idle_reload;
                        if (byte_idx == 2'd3) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= 31'(word_idx) << 2;
                            bus.wr_data <= {bus.rx_data, asm_reg};
                            byte_idx    <= '0;
                            word_idx    <= word_idx + 1'b1;
                            last_pend   <= last_word;
                        end else begin
                            asm_reg  <= {bus.rx_data, asm_reg[23:8]};
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end else if (timed_out) begin
                        state <= st_err;
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end
                default: begin
                    if (is_magic) begin
                        idle_cnt <= idle_reload;
                        state    <= st_cnt_lo;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = (state == st_cnt_lo) || (state == st_cnt_hi) || (state == st_data);
    assign bus.done     = (state == st_done);
    assign bus.err      = (state == st_err);
    assign bus.cpu_hold = (state != st_done);
endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: directed sequences, a vector table and
// random frames checked against a frame-parsing reference model.
module tb_imem_uart_loader;
    localparam int TO = 40;
    localparam int MAXW = 150;

    typedef struct packed {
        logic [30:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          len;
        logic [63:0] bytes;
        int          nw;
        logic        done;
        logic        err;
        logic [30:0] last_addr;
        logic [31:0] last_data;
    } vec_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    wr_t        mon_q[$];
    wr_t        exp_q[$];
    logic       exp_done;
    logic       exp_err;
    logic [7:0] fq[$];
    vec_t       vecs[7];

    imem_uart_loader_if bus();

    imem_uart_loader #(.MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.wr_en) begin
            mon_q.push_back('{addr: bus.wr_addr, data: bus.wr_data});
            check("wr_while_busy", 32'(bus.busy), 32'd1);
        end
    end

    // Reference: parse the frame as a whole, first A5 starts it.
    task automatic model(input logic [7:0] q[$]);
        int i;
        int n;
        int b;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        i = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        if (i + 2 >= q.size()) return;
        n = int'(q[i+1]) + 256 * int'(q[i+2]);
        if (n == 0) exp_done = 1'b1;
        else if (n > MAXW) exp_err = 1'b1;
        else begin
            for (int k = 0; k < n; k++) begin
                b = i + 3 + 4 * k;
                exp_q.push_back('{addr: 31'(4 * k), data: {q[b+3], q[b+2], q[b+1], q[b]}});
            end
            exp_done = 1'b1;
        end
    endtask

    task automatic send1(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$], input int gap_lo, input int gap_hi);
        int g;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = q[i];
            g = $urandom_range(gap_hi, gap_lo);
            repeat (g) begin
                @(negedge clk);
                bus.rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic cmp_writes(input string tag);
        check({tag, "_wr_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_wr_addr"}, 32'(mon_q[i].addr), 32'(exp_q[i].addr));
            check({tag, "_wr_data"}, mon_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
        check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
        check({tag, "_wr_data"},  bus.wr_data,       32'd0);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_err"},      32'(bus.err),      32'd0);
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 400000", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int junk;
        logic [7:0] jb;

        vectors = 0;
        miscompares = 0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b1;

        vecs[0] = '{3, 64'h00_00_A5,                   0, 1'b1, 1'b0, 31'h0, 32'h0};
        vecs[1] = '{3, 64'h00_97_A5,                   0, 1'b0, 1'b1, 31'h0, 32'h0};
        vecs[2] = '{7, 64'hDE_AD_BE_EF_00_01_A5,       1, 1'b1, 1'b0, 31'h0, 32'hDEADBEEF};
        vecs[3] = '{8, 64'hA5_A5_A5_A5_00_01_A5_5A,    1, 1'b1, 1'b0, 31'h0, 32'hA5A5A5A5};
        vecs[4] = '{3, 64'h01_00_A5,                   0, 1'b0, 1'b1, 31'h0, 32'h0};
        vecs[5] = '{3, 64'hFF_FF_A5,                   0, 1'b0, 1'b1, 31'h0, 32'h0};
        vecs[6] = '{4, 64'h00_00_A5_13,                0, 1'b1, 1'b0, 31'h0, 32'h0};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("post_reset_idle");

        // Two-word image with exact write latency and hold behaviour
        mon_q.delete();
        send1(8'hA5);
        check("t1_busy_after_magic", 32'(bus.busy), 32'd1);
        send1(8'h02); send1(8'h00);
        send1(8'h03); send1(8'h00); send1(8'h00); send1(8'h08);
        check("t1_w0_en",   32'(bus.wr_en),   32'd1);
        check("t1_w0_addr", 32'(bus.wr_addr), 32'd0);
        check("t1_w0_data", bus.wr_data,      32'h08000003);
        send1(8'h2D);
        check("t1_en_one_cycle", 32'(bus.wr_en), 32'd0);
        send1(8'h00); send1(8'h00); send1(8'h08);
        check("t1_w1_en",   32'(bus.wr_en),   32'd1);
        check("t1_w1_addr", 32'(bus.wr_addr), 32'd4);
        check("t1_w1_data", bus.wr_data,      32'h0800002D);
        @(negedge clk);
        check("t1_en_low",     32'(bus.wr_en),    32'd0);
        check("t1_addr_hold",  32'(bus.wr_addr),  32'd4);
        check("t1_data_hold",  bus.wr_data,       32'h0800002D);
        check("t1_done",       32'(bus.done),     32'd1);
        check("t1_cpu_hold",   32'(bus.cpu_hold), 32'd0);
        check("t1_busy",       32'(bus.busy),     32'd0);
        check("t1_count",      32'(mon_q.size()), 32'd2);

        // Zero-length image
        mon_q.delete();
        send1(8'hA5);
        check("t2_done_cleared", 32'(bus.done),     32'd0);
        check("t2_hold_set",     32'(bus.cpu_hold), 32'd1);
        send1(8'h00); send1(8'h00);
        check("t2_done",      32'(bus.done),     32'd1);
        check("t2_cpu_hold",  32'(bus.cpu_hold), 32'd0);
        check("t2_no_writes", 32'(mon_q.size()), 32'd0);

        // Oversize count, then recovery
        send1(8'hA5); send1(8'h97); send1(8'h00);
        check("t3_err",       32'(bus.err),      32'd1);
        check("t3_cpu_hold",  32'(bus.cpu_hold), 32'd1);
        check("t3_no_writes", 32'(mon_q.size()), 32'd0);
        send1(8'hA5);
        check("t3_err_cleared", 32'(bus.err), 32'd0);
        send1(8'h01); send1(8'h00);
        send1(8'h78); send1(8'h56); send1(8'h34); send1(8'h12);
        @(negedge clk);
        check("t3_done",  32'(bus.done), 32'd1);
        check("t3_count", 32'(mon_q.size()), 32'd1);
        if (mon_q.size() > 0) begin
            check("t3_addr", 32'(mon_q[0].addr), 32'd0);
            check("t3_data", mon_q[0].data, 32'h12345678);
        end

        // Inter-byte timeout mid-word
        mon_q.delete();
        send1(8'hA5); send1(8'h01); send1(8'h00); send1(8'h11); send1(8'h22);
        repeat (TO - 2) @(negedge clk);
        check("t4_no_err_early", 32'(bus.err),  32'd0);
        check("t4_busy_early",   32'(bus.busy), 32'd1);
        repeat (3) @(negedge clk);
        check("t4_err",       32'(bus.err),      32'd1);
        check("t4_cpu_hold",  32'(bus.cpu_hold), 32'd1);
        check("t4_no_writes", 32'(mon_q.size()), 32'd0);

        // Maximum image, bytes on every cycle
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'(MAXW)); fq.push_back(8'(MAXW >> 8));
        for (int i = 0; i < 4 * MAXW; i++) fq.push_back(8'($urandom_range(255, 0)));
        model(fq);
        mon_q.delete();
        send_q(fq, 0, 0);
        repeat (3) @(negedge clk);
        cmp_writes("t5");
        if (mon_q.size() > 0) check("t5_last_addr", 32'(mon_q[mon_q.size()-1].addr), 32'h254);
        check("t5_done", 32'(bus.done), 32'd1);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            fq.delete();
            for (int j = 0; j < vecs[v].len; j++) fq.push_back(vecs[v].bytes[8*j +: 8]);
            mon_q.delete();
            send_q(fq, 1, 1);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_done", v),     32'(bus.done),     32'(vecs[v].done));
            check($sformatf("vec%0d_err", v),      32'(bus.err),      32'(vecs[v].err));
            check($sformatf("vec%0d_cpu_hold", v), 32'(bus.cpu_hold), 32'(!vecs[v].done));
            check($sformatf("vec%0d_busy", v),     32'(bus.busy),     32'd0);
            check($sformatf("vec%0d_count", v),    32'(mon_q.size()), 32'(vecs[v].nw));
            if (vecs[v].nw > 0 && mon_q.size() > 0) begin
                check($sformatf("vec%0d_addr", v), 32'(mon_q[mon_q.size()-1].addr), 32'(vecs[v].last_addr));
                check($sformatf("vec%0d_data", v), mon_q[mon_q.size()-1].data, vecs[v].last_data);
            end
        end

        // Random frames against the reference model
        for (int f = 0; f < 40; f++) begin
            fq.delete();
            junk = $urandom_range(2, 0);
            for (int j = 0; j < junk; j++) begin
                jb = 8'($urandom_range(255, 0));
                if (jb == 8'hA5) jb = 8'h00;
                fq.push_back(jb);
            end
            if ($urandom_range(7, 0) == 0) n = $urandom_range(65535, MAXW + 1);
            else n = $urandom_range(6, 0);
            fq.push_back(8'hA5);
            fq.push_back(8'(n));
            fq.push_back(8'(n >> 8));
            if (n <= MAXW)
                for (int j = 0; j < 4 * n; j++) fq.push_back(8'($urandom_range(255, 0)));
            model(fq);
            mon_q.delete();
            send_q(fq, 0, 3);
            repeat (3) @(negedge clk);
            check($sformatf("rnd%0d_done", f),     32'(bus.done),     32'(exp_done));
            check($sformatf("rnd%0d_err", f),      32'(bus.err),      32'(exp_err));
            check($sformatf("rnd%0d_cpu_hold", f), 32'(bus.cpu_hold), 32'(!exp_done));
            cmp_writes($sformatf("rnd%0d", f));
        end

        // Reset in the middle of a word, then a fresh image
        send1(8'hA5); send1(8'h02); send1(8'h00); send1(8'h11); send1(8'h22);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("t6_mid_reset");
        @(negedge clk);
        reset = 1'b0;
        mon_q.delete();
        send1(8'hA5); send1(8'h01); send1(8'h00);
        send1(8'h44); send1(8'h33); send1(8'h22); send1(8'h11);
        repeat (2) @(negedge clk);
        check("t6_count", 32'(mon_q.size()), 32'd1);
        if (mon_q.size() > 0) begin
            check("t6_addr", 32'(mon_q[0].addr), 32'd0);
            check("t6_data", mon_q[0].data, 32'h11223344);
        end
        check("t6_done", 32'(bus.done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
